// File: rtl/branch_predict_unit.sv
// Branch resolve unit with a direct-mapped 2-bit counter BHT/BTB and registered mispredict redirect.
// Optional performance counters are compiled in with `define BPU_PERF_EN.
module branch_predict_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned IMM_W        = 16,
    parameter int unsigned OFFSET_SHIFT = 2,
    parameter int unsigned BHT_DEPTH    = 64,
    parameter logic [1:0]  CNT_INIT     = 2'b01
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [XLEN-1:0]  fetch_pc_i,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    input  logic             ex_valid_i,
    input  logic             ex_branch_i,
    input  logic             ex_bne_i,
    input  logic             ex_zero_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_pcp4_i,
    input  logic [IMM_W-1:0] ex_imm_i,
    input  logic             ex_pred_taken_i,
    input  logic [XLEN-1:0]  ex_pred_target_i,
    output logic [XLEN-1:0]  ex_sext_imm_o,
    output logic             branch_taken_o,
    output logic [XLEN-1:0]  branch_target_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o
`ifdef BPU_PERF_EN
    ,
    input  logic             perf_clr_i,
    output logic [31:0]      perf_branches_o,
    output logic [31:0]      perf_mispredicts_o
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [BHT_DEPTH-1:0] valid_q, valid_d;
    logic [1:0]           ctr_q [BHT_DEPTH];
    logic [TAG_W-1:0]     tag_q [BHT_DEPTH];
    logic [XLEN-1:0]      tgt_q [BHT_DEPTH];

    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic [1:0]       e_ctr;
    logic             act, upd, mispredict;
    logic             ctr_we, tgt_we, tag_we;
    logic [1:0]       ctr_wdata;

    // Lookup
    assign f_idx = fetch_pc_i[IDX_W+1:2];
    assign f_tag = fetch_pc_i[XLEN-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_taken_o  = f_hit & ctr_q[f_idx][1];
    assign pred_target_o = pred_taken_o ? tgt_q[f_idx] : fetch_pc_i + XLEN'(4);

    // Resolve
    assign ex_sext_imm_o   = {{(XLEN-IMM_W){ex_imm_i[IMM_W-1]}}, ex_imm_i};
    assign branch_target_o = ex_pcp4_i + (ex_sext_imm_o << OFFSET_SHIFT);
    assign branch_taken_o  = ex_branch_i & (ex_bne_i ? ~ex_zero_i : ex_zero_i);

    assign e_idx = ex_pc_i[IDX_W+1:2];
    assign e_tag = ex_pc_i[XLEN-1:IDX_W+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_ctr = ctr_q[e_idx];

    // The slot in EX during a redirect cycle is being flushed, so it must not train or redirect.
    assign act = ex_valid_i & ~redirect_q;
    assign upd = act & ex_branch_i;

    always_comb begin
        mispredict = 1'b0;
        if (act) begin
            if (ex_branch_i) begin
                mispredict = (branch_taken_o != ex_pred_taken_i) ||
                             (branch_taken_o && (ex_pred_target_i != branch_target_o));
            end else begin
                mispredict = ex_pred_taken_i;
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        ctr_we    = 1'b0;
        ctr_wdata = e_ctr;
        tgt_we    = 1'b0;
        tag_we    = 1'b0;
        if (upd) begin
            if (e_hit) begin
                ctr_we = 1'b1;
                if (branch_taken_o) begin
                    ctr_wdata = (e_ctr == 2'b11) ? 2'b11 : e_ctr + 2'b01;
                    tgt_we    = 1'b1;
                end else begin
                    ctr_wdata = (e_ctr == 2'b00) ? 2'b00 : e_ctr - 2'b01;
                end
            end else if (branch_taken_o) begin
                valid_d[e_idx] = 1'b1;
                ctr_we         = 1'b1;
                ctr_wdata      = 2'b10;
                tgt_we         = 1'b1;
                tag_we         = 1'b1;
            end
        end
        // A non-branch that hit in the table is an alias; drop the entry.
        if (act && !ex_branch_i && ex_pred_taken_i) begin
            valid_d[e_idx] = 1'b0;
        end
    end

    always_comb begin
        redirect_d    = mispredict;
        redirect_pc_d = redirect_pc_q;
        if (mispredict) begin
            redirect_pc_d = branch_taken_o ? branch_target_o : ex_pcp4_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= CNT_INIT;
            end
        end else begin
            valid_q       <= valid_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            if (ctr_we) begin
                ctr_q[e_idx] <= ctr_wdata;
            end
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (tgt_we) begin
            tgt_q[e_idx] <= branch_target_o;
        end
        if (tag_we) begin
            tag_q[e_idx] <= e_tag;
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

`ifdef BPU_PERF_EN
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_mp_q, perf_mp_d;

    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (perf_clr_i) begin
            perf_br_d = '0;
            perf_mp_d = '0;
        end else begin
            if (upd && (perf_br_q != '1)) begin
                perf_br_d = perf_br_q + 32'd1;
            end
            if (mispredict && (perf_mp_q != '1)) begin
                perf_mp_d = perf_mp_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches_o    = perf_br_q;
    assign perf_mispredicts_o = perf_mp_q;
`endif

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle BEQ/PC-select logic.
- Resolves BEQ/BNE in EX and computes the branch target.
- Keeps a direct-mapped branch history/target table: 2-bit saturating counter plus tag and target per entry.
- Gives fetch a taken/target prediction and issues a registered one-cycle redirect on misprediction.

Parameters:
- XLEN, 32, datapath/PC width.
- IMM_W, 16, branch offset field width; sign-extended to XLEN.
- OFFSET_SHIFT, 2, left shift applied to the extended offset (2 = word offsets).
- BHT_DEPTH, 64, table entries; power of 2, minimum 2. IDX_W = log2(BHT_DEPTH).
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  combinational prediction for fetch_pc.
- pred_target  out  XLEN  predicted next PC for fetch_pc.
- ex_valid  in  1  EX-stage instruction valid.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_bne  in  1  1 = BNE, 0 = BEQ.
- ex_zero  in  1  ALU zero flag.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_pcp4  in  XLEN  ex_pc + 4.
- ex_imm  in  IMM_W  raw offset field.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- ex_sext_imm  out  XLEN  sign-extended ex_imm, for the ALU-B mux.
- branch_taken  out  1  combinational resolved direction.
- branch_target  out  XLEN  combinational resolved target.
- redirect  out  1  registered flush/redirect pulse.
- redirect_pc  out  XLEN  registered correct next PC.

Behaviour:
- Reset (async, rst_n=0):
  - All entry valid bits = 0; all counters = CNT_INIT.
  - redirect = 0, redirect_pc = 0.
  - Tags and targets need not be reset.
- Indexing: idx = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2]. Same mapping for fetch_pc and ex_pc.
- Lookup (combinational):
  - hit = valid[idx] & (tag matches).
  - pred_taken = hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : fetch_pc + 4 (mod 2^XLEN).
- Resolve (combinational):
  - ex_sext_imm = sign-extend(ex_imm).
  - branch_target = ex_pcp4 + (ex_sext_imm << OFFSET_SHIFT), truncated to XLEN.
  - branch_taken = ex_branch & (ex_bne ? ~ex_zero : ex_zero).
- Accepted resolve: act = ex_valid & ~redirect. While redirect = 1, the EX slot is being squashed and is ignored: no table update, no new redirect.
- Mispredict, evaluated only when act = 1:
  - Branch: branch_taken != ex_pred_taken, or (branch_taken & ex_pred_target != branch_target).
  - Non-branch: ex_pred_taken = 1 (alias hit). Also invalidates valid[idx(ex_pc)].
- Redirect timing (1-cycle latency):
  - Next edge after a mispredict: redirect = 1, redirect_pc = branch_taken ? branch_target : ex_pcp4.
  - Otherwise redirect = 0 and redirect_pc holds its value.
  - redirect is never high two consecutive cycles.
- Table update, next edge, when act & ex_branch:
  - Tag hit, taken: ctr = min(ctr+1, 3); target = branch_target.
  - Tag hit, not taken: ctr = max(ctr-1, 0).
  - Miss, taken: allocate. valid = 1, tag written, target = branch_target, ctr = 2'b10.
  - Miss, not taken: no change.
- Same index read and written in one cycle: lookup returns the pre-edge contents (no bypass).
- Saturation: counter at 3 stays 3 on taken; counter at 0 stays 0 on not-taken.
- Reset asserted mid-operation: pending redirect is dropped and the table is invalidated immediately.

Optional Feature:
- Macro: BPU_PERF_EN.
- Defined:
  - Adds input perf_clr (1) and outputs perf_branches (32) and perf_mispredicts (32).
  - perf_branches increments on each act & ex_branch.
  - perf_mispredicts increments on each mispredict.
  - Both counters saturate at 2^32-1, clear on reset, and clear synchronously on perf_clr. perf_clr wins over a same-cycle increment.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then fetch_pc=0x40 -> pred_taken=0, pred_target=0x44. Table invalid; redirect=0.
- BEQ at ex_pc=0x40, ex_pcp4=0x44, ex_imm=0x0003, ex_zero=1, ex_pred_taken=0:
  - Same cycle: branch_target=0x50, branch_taken=1.
  - Next cycle: redirect=1, redirect_pc=0x50.
  - After: fetch_pc=0x40 -> pred_taken=1, pred_target=0x50.
- BNE at 0x80, ex_imm=0xFFFE, ex_zero=1, ex_pred_taken=1, ex_pred_target=0x7C:
  - branch_taken=0, ex_sext_imm=0xFFFFFFFE.
  - Next cycle: redirect_pc=0x84.
  - Hit entry counter decrements 2->1.
- Same branch resolved taken 4 times -> counter saturates at 3. Then one not-taken -> 2, and pred_taken stays 1.
- Mispredict with a second ex_valid in the redirect cycle -> second instruction ignored: no update and redirect low the following cycle.
- Under BPU_PERF_EN: 3 branches, 1 mispredict -> perf_branches=3, perf_mispredicts=1. Then perf_clr=1 -> both 0.
